// File: rtl/cep_tl_pkg.sv
// -----------------------------------------------------------------------------
// cep_tl_pkg
// Shared definitions for the TileLink system-side arbiter:
//   - state_t        : arbiter FSM state encoding (IDLE / WAIT / RESP)
//   - TIMEOUT_DATA   : read data returned when an access times out
//   - TIMEOUT_DEFAULT: default WAIT-state timeout in clock cycles
// -----------------------------------------------------------------------------
package cep_tl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [63:0] TIMEOUT_DATA    = 64'hDEAD_DEAD_DEAD_DEAD;
    localparam int          TIMEOUT_DEFAULT = 1024;

endpackage : cep_tl_pkg

// File: rtl/tl_rr_pick.sv
// -----------------------------------------------------------------------------
// tl_rr_pick
// Combinational round-robin selector. The search starts at the index just
// after the last grant and wraps modulo NUM_REQ.
// Ports:
//   eligible  in  NUM_REQ       requesters allowed to win this decision
//   last      in  clog2(NUM_REQ) index of the previous grant
//   found     out 1             at least one eligible requester
//   winner    out clog2(NUM_REQ) index of the selected requester
// -----------------------------------------------------------------------------
module tl_rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         eligible,
    input  logic [$clog2(NUM_REQ)-1:0] last,
    output logic                       found,
    output logic [$clog2(NUM_REQ)-1:0] winner
);

    localparam int ID_W = $clog2(NUM_REQ);

    // Walk from the farthest offset to the nearest so that the nearest
    // eligible requester after 'last' is the final assignment.
    always_comb begin
        int w_idx;
        found  = 1'b0;
        winner = '0;
        w_idx  = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx = (int'(last) + k) % NUM_REQ;
            if (eligible[w_idx]) begin
                found  = 1'b1;
                winner = ID_W'(w_idx);
            end
        end
    end

endmodule : tl_rr_pick

// File: rtl/tl_sys_arbiter.sv
// -----------------------------------------------------------------------------
// tl_sys_arbiter
// Round-robin arbiter/sequencer sharing one system-side access port among
// NUM_REQ requesters using the req/adr/rdWr/wrDat/rdDat/ack protocol.
// A timeout guard completes accesses the system side never acknowledges.
// Ports:
//   clock, reset   clock and synchronous active-high reset
//   req            per-requester level request
//   adr/rdWr/wrDat packed per-requester address, direction, write data
//   rdDat          read data broadcast to all requesters, valid with ack
//   ack            one-cycle completion pulse to the granted requester
//   err            high with ack when the access timed out
//   m_req/m_adr/m_rdWr/m_wrDat  downstream request port
//   m_rdDat/m_ack  downstream read data and acknowledge
//   grant_id       index of the current/last grant
//   busy           high while an access is in WAIT or RESP
// -----------------------------------------------------------------------------
module tl_sys_arbiter
    import cep_tl_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ADR_WIDTH = 32,
    parameter int TIMEOUT   = TIMEOUT_DEFAULT
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADR_WIDTH-1:0]  adr,
    input  logic [NUM_REQ-1:0]            rdWr,
    input  logic [NUM_REQ*64-1:0]         wrDat,
    output logic [63:0]                   rdDat,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          err,
    output logic                          m_req,
    output logic [ADR_WIDTH-1:0]          m_adr,
    output logic                          m_rdWr,
    output logic [63:0]                   m_wrDat,
    input  logic [63:0]                   m_rdDat,
    input  logic                          m_ack,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [ID_W-1:0]  LAST_RST = ID_W'(NUM_REQ - 1);

    state_t               r_state;
    logic [NUM_REQ-1:0]   r_done;
    logic [ID_W-1:0]      r_last;
    logic [ID_W-1:0]      r_grant;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_busy;
    logic [NUM_REQ-1:0]   r_ack;
    logic                 r_err;
    logic [63:0]          r_rdDat;
    logic                 r_m_req;
    logic [ADR_WIDTH-1:0] r_m_adr;
    logic                 r_m_rdWr;
    logic [63:0]          r_m_wrDat;

    logic [NUM_REQ-1:0]   w_eligible;
    logic                 w_found;
    logic [ID_W-1:0]      w_win;
    logic [ADR_WIDTH-1:0] w_sel_adr;
    logic                 w_sel_rdWr;
    logic [63:0]          w_sel_wrDat;

    // A requester that has just been served stays ineligible until its req
    // is seen low, so a late-dropping req cannot win a second time.
    assign w_eligible = req & ~r_done;

    tl_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .eligible (w_eligible),
        .last     (r_last),
        .found    (w_found),
        .winner   (w_win)
    );

    // Winner's request fields, selected by index.
    always_comb begin
        w_sel_adr   = '0;
        w_sel_rdWr  = 1'b0;
        w_sel_wrDat = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == ID_W'(i)) begin
                w_sel_adr   = adr[i*ADR_WIDTH +: ADR_WIDTH];
                w_sel_rdWr  = rdWr[i];
                w_sel_wrDat = wrDat[i*64 +: 64];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_done    <= '0;
            r_last    <= LAST_RST;
            r_grant   <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_ack     <= '0;
            r_err     <= 1'b0;
            r_rdDat   <= '0;
            r_m_req   <= 1'b0;
            r_m_adr   <= '0;
            r_m_rdWr  <= 1'b0;
            r_m_wrDat <= '0;
        end else begin
            r_ack  <= '0;
            r_done <= r_done & req;
            case (r_state)
                ST_IDLE: begin
                    // A level m_ack still high from the previous access must
                    // fall before a new access is issued.
                    if (w_found && !m_ack) begin
                        r_m_adr   <= w_sel_adr;
                        r_m_rdWr  <= w_sel_rdWr;
                        r_m_wrDat <= w_sel_wrDat;
                        r_m_req   <= 1'b1;
                        r_grant   <= w_win;
                        r_last    <= w_win;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (m_ack) begin
                        r_rdDat        <= r_m_rdWr ? m_rdDat : 64'd0;
                        r_err          <= 1'b0;
                        r_m_req        <= 1'b0;
                        r_ack[r_grant] <= 1'b1;
                        r_cnt          <= '0;
                        r_state        <= ST_RESP;
                    end else if (TIMEOUT > 0) begin
                        if (r_cnt == CNT_LAST) begin
                            r_rdDat        <= TIMEOUT_DATA;
                            r_err          <= 1'b1;
                            r_m_req        <= 1'b0;
                            r_ack[r_grant] <= 1'b1;
                            r_cnt          <= '0;
                            r_state        <= ST_RESP;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    // Overrides the req-low clear above for the served bit.
                    r_done[r_grant] <= 1'b1;
                    r_busy          <= 1'b0;
                    r_state         <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rdDat    = r_rdDat;
    assign ack      = r_ack;
    assign err      = r_err;
    assign m_req    = r_m_req;
    assign m_adr    = r_m_adr;
    assign m_rdWr   = r_m_rdWr;
    assign m_wrDat  = r_m_wrDat;
    assign grant_id = r_grant;
    assign busy     = r_busy;

endmodule : tl_sys_arbiter

// File: tb/tb_tl_sys_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tl_sys_arbiter
// Directed self-checking bench for tl_sys_arbiter (NUM_REQ=4, TIMEOUT=16).
// Inputs change 1 time unit after the rising edge; outputs are checked there.
// -----------------------------------------------------------------------------
module tb_tl_sys_arbiter;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int TO = 16;

    logic              clock;
    logic              reset;
    logic [NR-1:0]     req;
    logic [NR*AW-1:0]  adr;
    logic [NR-1:0]     rdWr;
    logic [NR*64-1:0]  wrDat;
    logic [63:0]       rdDat;
    logic [NR-1:0]     ack;
    logic              err;
    logic              m_req;
    logic [AW-1:0]     m_adr;
    logic              m_rdWr;
    logic [63:0]       m_wrDat;
    logic [63:0]       m_rdDat;
    logic              m_ack;
    logic [1:0]        grant_id;
    logic              busy;

    int n_chk;
    int n_fail;

    tl_sys_arbiter #(
        .NUM_REQ   (NR),
        .ADR_WIDTH (AW),
        .TIMEOUT   (TO)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .adr      (adr),
        .rdWr     (rdWr),
        .wrDat    (wrDat),
        .rdDat    (rdDat),
        .ack      (ack),
        .err      (err),
        .m_req    (m_req),
        .m_adr    (m_adr),
        .m_rdWr   (m_rdWr),
        .m_wrDat  (m_wrDat),
        .m_rdDat  (m_rdDat),
        .m_ack    (m_ack),
        .grant_id (grant_id),
        .busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Wait (bounded) for the next downstream request.
    task automatic wait_issue(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (m_req) break;
            tick();
        end
        check_val({tag, "_issue"}, {63'd0, m_req}, 64'd1);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        req     = '0;
        m_ack   = 1'b0;
        tick();
        tick();
        reset   = 1'b0;
    endtask

    initial begin
        int hi_cnt;
        int ack_cnt;
        int order [5];
        n_chk   = 0;
        n_fail  = 0;
        req     = '0;
        adr     = '0;
        rdWr    = '0;
        wrDat   = '0;
        m_rdDat = '0;
        m_ack   = 1'b0;
        reset   = 1'b1;
        #1;

        // ---------------- reset state ----------------
        tick();
        tick();
        check_val("rst_m_req", {63'd0, m_req}, 64'd0);
        check_val("rst_m_adr", {32'd0, m_adr}, 64'd0);
        check_val("rst_ack", {60'd0, ack}, 64'd0);
        check_val("rst_rdDat", rdDat, 64'd0);
        check_val("rst_grant", {62'd0, grant_id}, 64'd0);
        check_val("rst_busy", {63'd0, busy}, 64'd0);
        reset = 1'b0;
        tick();

        // ---------------- single read ----------------
        adr[2*AW +: AW] = 32'h0000_1000;
        rdWr[2] = 1'b1;
        req[2]  = 1'b1;
        tick();
        check_val("rd_m_req", {63'd0, m_req}, 64'd1);
        check_val("rd_m_adr", {32'd0, m_adr}, 64'h1000);
        check_val("rd_m_rdWr", {63'd0, m_rdWr}, 64'd1);
        check_val("rd_grant", {62'd0, grant_id}, 64'd2);
        check_val("rd_busy", {63'd0, busy}, 64'd1);
        tick();
        tick();
        m_rdDat = 64'h1234_5678_9ABC_DEF0;
        m_ack   = 1'b1;
        tick();
        check_val("rd_ack", {60'd0, ack}, 64'b0100);
        check_val("rd_rdDat", rdDat, 64'h1234_5678_9ABC_DEF0);
        check_val("rd_err", {63'd0, err}, 64'd0);
        check_val("rd_m_req_low", {63'd0, m_req}, 64'd0);
        m_ack  = 1'b0;
        req[2] = 1'b0;
        tick();
        check_val("rd_ack_single", {60'd0, ack}, 64'd0);
        check_val("rd_busy_low", {63'd0, busy}, 64'd0);

        // ---------------- four-way contention ----------------
        do_reset();
        for (int i = 0; i < NR; i++) adr[i*AW +: AW] = 32'(i * 32'h100);
        rdWr = '0;
        req  = '1;
        for (int g = 0; g < 5; g++) begin
            wait_issue("rr");
            order[g] = int'(grant_id);
            m_ack = 1'b1;
            tick();
            m_ack = 1'b0;
            check_val("rr_ack", {60'd0, ack}, 64'(4'b0001 << order[g]));
            req[order[g]] = 1'b0;
            tick();
            tick();
            req[order[g]] = 1'b1;
        end
        check_val("rr_g0", 64'(order[0]), 64'd0);
        check_val("rr_g1", 64'(order[1]), 64'd1);
        check_val("rr_g2", 64'(order[2]), 64'd2);
        check_val("rr_g3", 64'(order[3]), 64'd3);
        check_val("rr_g4", 64'(order[4]), 64'd0);

        // ---------------- late req drop ----------------
        do_reset();
        rdWr   = '1;
        req[1] = 1'b1;
        wait_issue("late");
        check_val("late_grant1", {62'd0, grant_id}, 64'd1);
        req[3] = 1'b1;
        m_ack  = 1'b1;
        tick();
        m_ack  = 1'b0;
        check_val("late_ack1", {60'd0, ack}, 64'b0010);
        tick();
        tick();
        check_val("late_grant3", {62'd0, grant_id}, 64'd3);
        check_val("late_m_req", {63'd0, m_req}, 64'd1);
        req[1] = 1'b0;
        m_ack  = 1'b1;
        tick();
        m_ack  = 1'b0;
        check_val("late_ack3", {60'd0, ack}, 64'b1000);
        req[3] = 1'b0;
        tick();
        tick();

        // served requester holding req alone is not re-granted
        req[0] = 1'b1;
        wait_issue("mask");
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        check_val("mask_ack0", {60'd0, ack}, 64'b0001);
        tick();
        tick();
        check_val("mask_block_a", {63'd0, m_req}, 64'd0);
        tick();
        check_val("mask_block_b", {63'd0, m_req}, 64'd0);
        req[0] = 1'b0;
        tick();
        req[0] = 1'b1;
        tick();
        check_val("mask_regrant", {63'd0, m_req}, 64'd1);
        m_ack = 1'b1;
        tick();
        m_ack  = 1'b0;
        req[0] = 1'b0;
        tick();

        // ---------------- timeout ----------------
        do_reset();
        req[2] = 1'b1;
        wait_issue("to");
        hi_cnt = 0;
        while (m_req && hi_cnt < 40) begin
            hi_cnt++;
            tick();
        end
        check_val("to_m_req_cycles", 64'(hi_cnt), 64'(TO));
        check_val("to_ack", {60'd0, ack}, 64'b0100);
        check_val("to_err", {63'd0, err}, 64'd1);
        check_val("to_rdDat", rdDat, 64'hDEAD_DEAD_DEAD_DEAD);
        req[2]  = 1'b0;
        m_rdDat = 64'h5555_5555_5555_5555;
        m_ack   = 1'b1;
        tick();
        check_val("to_late_ack", {60'd0, ack}, 64'd0);
        tick();
        check_val("to_rdDat_hold", rdDat, 64'hDEAD_DEAD_DEAD_DEAD);
        check_val("to_err_hold", {63'd0, err}, 64'd1);
        m_ack = 1'b0;

        // ---------------- mid-access reset ----------------
        do_reset();
        req[1] = 1'b1;
        wait_issue("mr");
        check_val("mr_grant1", {62'd0, grant_id}, 64'd1);
        reset  = 1'b1;
        req    = '0;
        tick();
        check_val("mr_m_req", {63'd0, m_req}, 64'd0);
        check_val("mr_m_adr", {32'd0, m_adr}, 64'd0);
        check_val("mr_busy", {63'd0, busy}, 64'd0);
        check_val("mr_grant", {62'd0, grant_id}, 64'd0);
        check_val("mr_ack", {60'd0, ack}, 64'd0);
        check_val("mr_rdDat", rdDat, 64'd0);
        reset = 1'b0;
        tick();
        check_val("mr_no_ack", {60'd0, ack}, 64'd0);
        req[3] = 1'b1;
        req[0] = 1'b1;
        tick();
        check_val("mr_first_grant", {62'd0, grant_id}, 64'd0);
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        req   = '0;
        tick();
        tick();

        // ---------------- write path ----------------
        do_reset();
        rdWr               = '0;
        wrDat[0 +: 64]     = 64'h0000_0000_0000_CAFE;
        m_rdDat            = 64'hFFFF_FFFF_FFFF_FFFF;
        req[0]             = 1'b1;
        wait_issue("wr");
        check_val("wr_m_wrDat", m_wrDat, 64'hCAFE);
        check_val("wr_m_rdWr", {63'd0, m_rdWr}, 64'd0);
        req[1]  = 1'b1;
        m_ack   = 1'b1;
        ack_cnt = 0;
        tick();
        check_val("wr_ack", {60'd0, ack}, 64'b0001);
        check_val("wr_rdDat_zero", rdDat, 64'd0);
        if (ack != '0) ack_cnt++;
        req[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (ack != '0) ack_cnt++;
            check_val("wr_hold_no_issue", {63'd0, m_req}, 64'd0);
        end
        check_val("wr_ack_pulses", 64'(ack_cnt), 64'd1);
        m_ack = 1'b0;
        tick();
        check_val("wr_next_issue", {63'd0, m_req}, 64'd1);
        check_val("wr_next_grant", {62'd0, grant_id}, 64'd1);
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        req   = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global bound on simulation time.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_tl_sys_arbiter
